// File: rtl/vid_pixel_fifo.sv
// Parametrised synchronous pixel FIFO with occupancy level, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush. Define PIXFIFO_FWFT_EN for first-word-fall-through reads.
module vid_pixel_fifo #(
    parameter int unsigned  DATA_W = 24,
    parameter int unsigned  DEPTH  = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    input  logic [AW:0]       af_thresh,
    input  logic [AW:0]       ae_thresh,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
            $error("vid_pixel_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level_q;
    logic [AW:0]       level_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              unf_set;

    // Status flags decode the registered level only.
    assign level        = level_q;
    assign full         = (level_q == DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);

    // Flush masks both ports; rejected operations only raise the sticky flags.
    always_comb begin
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        level_nxt = level_q;
        if (!flush) begin
            wr_acc  = wr_en && !full;
            rd_acc  = rd_en && !empty;
            ovf_set = wr_en && full;
            unf_set = rd_en && empty;
        end
        if (flush) begin
            level_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            level_nxt = level_q + ONE_L;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level_q - ONE_L;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            level_q <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + ONE_L;
                if (rd_acc) rd_ptr <= rd_ptr + ONE_L;
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (unf_set)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

    // Storage array is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

`ifdef PIXFIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_vid_pixel_fifo.sv
// Scoreboard bench for vid_pixel_fifo (standard read mode, DEPTH=16, DATA_W=24).
module tb_vid_pixel_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, wr_en, rd_en, err_clr;
    logic [23:0] wr_data;
    logic [23:0] rd_data;
    logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  af_thresh, ae_thresh, level;

    int checks = 0;
    int errors = 0;

    logic [23:0] m_q[$];
    logic [23:0] exp_q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    vid_pixel_fifo #(.DATA_W(24), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .almost_full(almost_full),
        .almost_empty(almost_empty), .level(level), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Each read accepted at an edge must show up as one rd_valid pulse with the head data.
    always @(negedge clk) begin
        chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
        if (rd_valid && exp_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end

    task automatic check_state(input string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".level"}, 32'(level), 32'(sz));
        chk({tag, ".full"}, 32'(full), 32'(sz == 16));
        chk({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= int'(af_thresh)));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= int'(ae_thresh)));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic step(input logic w, input logic [23:0] d, input logic r,
                        input logic fl, input logic ec);
        int sz;
        wr_en = w; wr_data = d; rd_en = r; flush = fl; err_clr = ec;
        @(posedge clk);
        sz = m_q.size();
        if (fl) begin
            m_q.delete();
        end else begin
            if (r && sz > 0)  exp_q.push_back(m_q.pop_front());
            if (w && sz < 16) m_q.push_back(d);
        end
        if (!fl && w && sz == 16) m_ovf = 1'b1;
        else if (ec)              m_ovf = 1'b0;
        if (!fl && r && sz == 0)  m_unf = 1'b1;
        else if (ec)              m_unf = 1'b0;
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_state("step");
    endtask

    task automatic wr(input logic [23:0] d);  step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic rd();                      step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0); endtask
    task automatic wrd(input logic [23:0] d); step(1'b1, d, 1'b1, 1'b0, 1'b0); endtask
    task automatic idle();                    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0); endtask
    task automatic eclr();                    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        wr_data = 24'h0; af_thresh = 5'd12; ae_thresh = 5'd3;
        #12;
        chk("rst.rd_data", 32'(rd_data), 32'h0);
        chk("rst.rd_valid", 32'(rd_valid), 32'h0);
        check_state("rst");
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) wr(24'(i));
        chk("t1.full", 32'(full), 32'h1);
        chk("t1.level16", 32'(level), 32'd16);
        wr(24'hBAD);
        chk("t1.overflow", 32'(overflow), 32'h1);
        chk("t1.level_after_ovf", 32'(level), 32'd16);
        repeat (16) rd();
        idle();
        chk("t1.empty", 32'(empty), 32'h1);
        eclr();
        chk("t1.ovf_cleared", 32'(overflow), 32'h0);

        // Underflow and err_clr priority
        rd();
        chk("t2.underflow", 32'(underflow), 32'h1);
        chk("t2.level0", 32'(level), 32'd0);
        eclr();
        chk("t2.unf_cleared", 32'(underflow), 32'h0);
        step(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
        chk("t2.set_beats_clr", 32'(underflow), 32'h1);
        eclr();

        // Simultaneous read/write at level 5 and at full
        for (int i = 0; i < 5; i++) wr(24'h100 + 24'(i));
        for (int i = 0; i < 8; i++) begin
            wrd(24'h200 + 24'(i));
            chk("t3.level5", 32'(level), 32'd5);
        end
        for (int i = 0; i < 11; i++) wr(24'h300 + 24'(i));
        chk("t3.level16", 32'(level), 32'd16);
        wrd(24'hBEE);
        chk("t3.level15", 32'(level), 32'd15);
        chk("t3.overflow", 32'(overflow), 32'h1);
        repeat (15) rd();
        eclr();

        // Threshold edges: af=12, ae=3
        for (int i = 1; i <= 16; i++) begin
            wr(24'h400 + 24'(i));
            if (i == 3)  chk("t4.ae_at3", 32'(almost_empty), 32'h1);
            if (i == 4)  chk("t4.ae_at4", 32'(almost_empty), 32'h0);
            if (i == 11) chk("t4.af_at11", 32'(almost_full), 32'h0);
            if (i == 12) chk("t4.af_at12", 32'(almost_full), 32'h1);
        end
        for (int i = 15; i >= 0; i--) begin
            rd();
            if (i == 12) chk("t4.drain_af12", 32'(almost_full), 32'h1);
            if (i == 11) chk("t4.drain_af11", 32'(almost_full), 32'h0);
            if (i == 4)  chk("t4.drain_ae4", 32'(almost_empty), 32'h0);
            if (i == 3)  chk("t4.drain_ae3", 32'(almost_empty), 32'h1);
        end

        // Streaming with level 0..3, pointers wrap
        n = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) begin wr(24'h500 + 24'(n)); n++; end
            wrd(24'h500 + 24'(n)); n++;
            repeat (3) rd();
        end
        idle();
        chk("t5.empty", 32'(empty), 32'h1);

        // Async reset mid-cycle
        for (int i = 0; i < 7; i++) wr(24'h600 + 24'(i));
        chk("t6.level7", 32'(level), 32'd7);
        #2 reset_n = 1'b0;
        m_q.delete(); exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        chk("t6.rst_empty", 32'(empty), 32'h1);
        chk("t6.rst_level", 32'(level), 32'd0);
        chk("t6.rst_rd_valid", 32'(rd_valid), 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Flush preserves overflow, ignores simultaneous rd/wr
        for (int i = 0; i < 16; i++) wr(24'h700 + 24'(i));
        wr(24'hBAD);
        repeat (7) rd();
        chk("t6.level9", 32'(level), 32'd9);
        chk("t6.ovf_before_flush", 32'(overflow), 32'h1);
        step(1'b1, 24'hABC, 1'b1, 1'b1, 1'b0);
        chk("t6.flush_level", 32'(level), 32'd0);
        chk("t6.flush_empty", 32'(empty), 32'h1);
        chk("t6.flush_ovf_kept", 32'(overflow), 32'h1);
        chk("t6.flush_no_unf", 32'(underflow), 32'h0);
        wr(24'h800);
        rd();
        idle();
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
